// File: rtl/rng4_pkg.sv
// rng4_pkg: shared state enum, seed and feedback function for the 4-bit random source
package rng4_pkg;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  localparam logic [3:0] SEED = 4'hA;
  function automatic logic rng4_next_bit(input logic [3:0] q);
    return q[3] ^ q[2];
  endfunction
endpackage

// File: rtl/rng4_predict.sv
// rng4_predict: prediction bit and next history, either self-synchronising or regenerating
module rng4_predict
  import rng4_pkg::*;
(
  input  logic [3:0] hist,
  input  logic       bit_in,
  input  logic       regen,
  output logic       pred,
  output logic [3:0] hist_nxt
);
  assign pred     = rng4_next_bit(hist);
  assign hist_nxt = {hist[2:0], regen ? pred : bit_in};
endmodule

// File: rtl/rng4_chk.sv
// rng4_chk: serial lock/error checker for the 4-bit maximal-length sequence (err_cnt gated by RNG4_CHK_ERRCNT_EN)
module rng4_chk
  import rng4_pkg::*;
#(
  parameter int LOCK_CNT  = 8,
  parameter int WIN_LEN   = 16,
  parameter int LOSS_ERRS = 3,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       hist
);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int LW = $clog2(LOSS_ERRS + 1);
  localparam logic [3:0]    LC = 4'(LOCK_CNT);
  localparam logic [WW-1:0] WL = WW'(WIN_LEN);
  localparam logic [LW-1:0] LE = LW'(LOSS_ERRS);
  state_t          state, state_n;
  logic [3:0]      hist_n, hist_p, mc, mc_n;
  logic [2:0]      fill, fill_n;
  logic [WW-1:0]   win, win_n;
  logic [LW-1:0]   werr, werr_n;
  logic            pred, pulse_n;
  rng4_predict u_pred (
    .hist     (hist),
    .bit_in   (bit_in),
    .regen    (state == LOCKED),
    .pred     (pred),
    .hist_nxt (hist_p)
  );
  assign locked = (state == LOCKED);
  // next-state: search fill, verify match run, locked window/error tracking
  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    mc_n    = mc;
    win_n   = win;
    werr_n  = werr;
    pulse_n = 1'b0;
    if (bit_valid) begin
      hist_n = hist_p;
      case (state)
        SEARCH: begin
          fill_n = fill + 3'd1;
          if (hist_p == 4'd0) fill_n = '0;
          else if (fill_n == 3'd4) begin
            state_n = VERIFY;
            fill_n  = '0;
            mc_n    = '0;
          end
        end
        VERIFY: begin
          mc_n = (bit_in == pred) ? mc + 4'd1 : '0;
          if (hist_p == 4'd0) state_n = SEARCH;
          else if (mc_n == LC) begin
            state_n = LOCKED;
            win_n   = '0;
            werr_n  = '0;
          end
        end
        default: begin
          pulse_n = (bit_in != pred);
          werr_n  = werr + LW'(pulse_n);
          win_n   = (win + WW'(1) == WL) ? '0 : win + WW'(1);
          if (werr_n == LE) begin
            state_n = SEARCH;
            fill_n  = '0;
          end else if (win_n == '0) werr_n = '0;
        end
      endcase
    end
  end
  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      hist      <= '0;
      fill      <= '0;
      mc        <= '0;
      win       <= '0;
      werr      <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      hist      <= hist_n;
      fill      <= fill_n;
      mc        <= mc_n;
      win       <= win_n;
      werr      <= werr_n;
      err_pulse <= pulse_n;
    end
  end
`ifdef RNG4_CHK_ERRCNT_EN
  logic [ERR_W-1:0] cnt;
  // saturating error count, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (pulse_n && cnt != '1) cnt <= cnt + ERR_W'(1);
  end
  assign err_cnt = cnt;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_rng4_chk.sv
// tb_rng4_chk: directed checks of lock, error counting, loss of lock, gaps and async reset
module tb_rng4_chk;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       locked, err_pulse;
  logic [7:0] err_cnt;
  logic [3:0] hist;
  int checks = 0, failures = 0, pulses = 0, idx = 0, viol = 0;
  logic seqv [0:14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  rng4_chk dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .hist      (hist)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (err_pulse) pulses++;
  function automatic int ec(input int n);
`ifdef RNG4_CHK_ERRCNT_EN
    return n;
`else
    return 0;
`endif
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask
  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      send(seqv[idx]);
      idx = (idx + 1) % 15;
    end
  endtask
  task automatic bad();
    send(~seqv[idx]);
    idx = (idx + 1) % 15;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idx = 0;
  endtask
  initial begin
    do_reset();
    chk("rst_locked", int'(locked), 0);
    chk("rst_hist", int'(hist), 0);
    chk("rst_errcnt", int'(err_cnt), 0);
    chk("rst_pulse", int'(err_pulse), 0);
    pulses = 0;
    clean(4);
    chk("fill_hist", int'(hist), 4'hF);
    clean(7);
    chk("lock_11", int'(locked), 0);
    clean(1);
    chk("lock_12", int'(locked), 1);
    chk("lock_hist", int'(hist), 4'h3);
    chk("clean_errcnt", int'(err_cnt), 0);
    chk("clean_pulses", pulses, 0);
    pulses = 0;
    bad();
    chk("e1_pulse", int'(err_pulse), 1);
    chk("e1_errcnt", int'(err_cnt), ec(1));
    chk("e1_locked", int'(locked), 1);
    clean(15);
    chk("e1_pulses", pulses, 1);
    chk("e1_still_locked", int'(locked), 1);
    chk("e1_errcnt_hold", int'(err_cnt), ec(1));
    pulses = 0;
    bad();
    clean(1);
    bad();
    clean(1);
    chk("e3_locked_2err", int'(locked), 1);
    bad();
    chk("e3_unlock", int'(locked), 0);
    chk("e3_pulse", int'(err_pulse), 1);
    chk("e3_errcnt", int'(err_cnt), ec(3));
    clean(11);
    chk("relock_11", int'(locked), 0);
    clean(1);
    chk("relock_12", int'(locked), 1);
    chk("relock_errcnt", int'(err_cnt), ec(3));
    chk("e3_pulses", pulses, 3);
    bad();
    clean(15);
    bad();
    chk("e5_locked", int'(locked), 1);
    chk("e5_errcnt", int'(err_cnt), ec(5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", int'(locked), 0);
    chk("arst_pulse", int'(err_pulse), 0);
    chk("arst_errcnt", int'(err_cnt), 0);
    chk("arst_hist", int'(hist), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idx = 0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      send(1'b0);
      if (locked !== 1'b0 || hist !== 4'd0) viol++;
    end
    chk("zeros_viol", viol, 0);
    do_reset();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      clean(1);
      bit_in = 1'($urandom);
      @(posedge clk);
      #1;
      if (i == 10) chk("gap_lock_11", int'(locked), 0);
    end
    chk("gap_lock_12", int'(locked), 1);
    chk("gap_pulses", pulses, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
